// File: rtl/divider_8b_if.sv
// Operand/result handshake bundle for divider_8b: valid/ready on the input
// side (dividend, divisor) and on the output side (quotient, remainder, div_zero).
interface divider_8b_if #(
  parameter int unsigned WIDTH_N = 8,
  parameter int unsigned WIDTH_D = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic               div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/divider_8b.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIVIDER_ZERO_DETECT_EN: zero divisor short-circuits to DONE and flags div_zero.
module divider_8b #(
  parameter int unsigned WIDTH_N = 8,
  parameter int unsigned WIDTH_D = 4
) (
  input logic         clk,
  input logic         rst,
  divider_8b_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH_N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH_N-1:0] r_shift;
  logic [WIDTH_D-1:0] r_rem;
  logic [WIDTH_D-1:0] r_divisor;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_zero_div;
  logic [WIDTH_D:0]   w_trial;
  logic               w_ge;
  logic [WIDTH_D-1:0] w_rem_nxt;

  assign w_accept = bus.in_valid & r_in_ready;

`ifdef DIVIDER_ZERO_DETECT_EN
  assign w_zero_div = (bus.divisor == '0);
`else
  assign w_zero_div = 1'b0;
`endif

  // One restoring step: bring down the next dividend bit and try the subtract.
  assign w_trial   = {r_rem, r_shift[WIDTH_N-1]};
  assign w_ge      = (w_trial >= {1'b0, r_divisor});
  assign w_rem_nxt = w_ge ? WIDTH_D'(w_trial - {1'b0, r_divisor})
                          : w_trial[WIDTH_D-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_zero_div ? DONE : RUN;
      RUN:     if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // The dividend shift register fills with quotient bits from the LSB end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_zero_div) begin
              r_shift <= '1;
              r_rem   <= bus.dividend[WIDTH_D-1:0];
            end else begin
              r_shift <= bus.dividend;
              r_rem   <= '0;
            end
            r_divisor <= bus.divisor;
            r_cnt     <= CNT_W'(WIDTH_N);
          end
        end
        RUN: begin
          r_shift <= {r_shift[WIDTH_N-2:0], w_ge};
          r_rem   <= w_rem_nxt;
          r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DIVIDER_ZERO_DETECT_EN
  logic r_div_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_div_zero <= 1'b0;
    else if (w_accept) r_div_zero <= w_zero_div;
  end

  assign bus.div_zero = r_div_zero;
`else
  assign bus.div_zero = 1'b0;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_shift;
  assign bus.remainder = r_rem;
endmodule

// File: tb/tb_divider_8b.sv
// Self-checking bench for divider_8b: directed cases, back-pressure, reset
// mid-run, exhaustive multiplier round trip and random operands vs. a reference model.
module tb_divider_8b;
  localparam int unsigned WN = 8;
  localparam int unsigned WD = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  divider_8b_if #(.WIDTH_N(WN), .WIDTH_D(WD)) bus ();

  divider_8b #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Divide a by b; noise drives random operands/in_valid while busy;
  // hold keeps out_ready low for that many cycles once the result is up.
  task automatic do_div(input logic [WN-1:0] a, input logic [WD-1:0] b,
                        input bit noise, input int hold, input string tag);
    int               lat;
    int               wt;
    int               exp_lat;
    logic [WN-1:0]    exp_q;
    logic [WD-1:0]    exp_r;
    logic             exp_dz;
    logic [WN-1:0]    q0;
    logic [WD-1:0]    r0;

    if (b == 0) begin
      exp_q = '1;
      exp_r = a[WD-1:0];
    end else begin
      exp_q = WN'(a / b);
      exp_r = WD'(a % b);
    end
`ifdef DIVIDER_ZERO_DETECT_EN
    exp_dz  = (b == 0);
    exp_lat = (b == 0) ? 1 : WN + 1;
`else
    exp_dz  = 1'b0;
    exp_lat = WN + 1;
`endif

    wt = 0;
    while (bus.in_ready !== 1'b1 && wt < 30) begin
      step();
      wt++;
    end
    chk({tag, "_ready_wait"}, 32'(wt < 30), 32'd1);

    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.in_valid = 1'b0;

    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (noise) begin
        bus.in_valid = 1'($urandom);
        bus.dividend = WN'($urandom);
        bus.divisor  = WD'($urandom);
      end
      step();
      lat++;
    end
    bus.in_valid = 1'b0;

    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_quotient"}, 32'(bus.quotient), 32'(exp_q));
    chk({tag, "_remainder"}, 32'(bus.remainder), 32'(exp_r));
    chk({tag, "_div_zero"}, 32'(bus.div_zero), 32'(exp_dz));

    q0 = bus.quotient;
    r0 = bus.remainder;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom);
      bus.dividend = WN'($urandom);
      bus.divisor  = WD'($urandom);
      step();
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_hold_q"}, 32'(bus.quotient), 32'(exp_q));
      chk({tag, "_hold_r"}, 32'(bus.remainder), 32'(exp_r));
    end
    bus.in_valid = 1'b0;
    // q0/r0 captured at first valid must also match the model
    chk({tag, "_first_q"}, 32'(q0), 32'(exp_q));
    chk({tag, "_first_r"}, 32'(r0), 32'(exp_r));

    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [WN-1:0] ra;
    logic [WD-1:0] rb;

    n_chk         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    do_div(8'd200, 4'd7, 1'b0, 0, "basic");
    do_div(8'd255, 4'd1, 1'b0, 0, "max_by_one");
    do_div(8'd5, 4'd15, 1'b0, 0, "small_by_big");
    do_div(8'd0, 4'd9, 1'b0, 0, "zero_dividend");
    do_div(8'hA7, 4'd0, 1'b0, 0, "zero_divisor");
    do_div(8'd100, 4'd3, 1'b1, 5, "backpressure");

    // Reset four cycles into a division must clear everything without a clock edge.
    bus.in_valid = 1'b1;
    bus.dividend = 8'd143;
    bus.divisor  = 4'd11;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_quotient", 32'(bus.quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.remainder), 32'd0);
    step();
    rst = 1'b0;
    step();
    do_div(8'd143, 4'd11, 1'b0, 0, "after_rst");

    for (int x = 1; x <= 15; x++) begin
      for (int y = 1; y <= 15; y++) begin
        do_div(WN'(x * y), WD'(y), 1'b0, 0, "roundtrip");
      end
    end

    for (int i = 0; i < 40; i++) begin
      ra = WN'($urandom);
      rb = (i % 8 == 0) ? '0 : WD'($urandom);
      do_div(ra, rb, i[0], i % 3, "random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
